mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares one external memory bus (address, data, MREQ, WRITE, SIZE, active-low ACK) between the IF-stage fetch port and the MEM-stage load/store port.
- Sits between the pipeline stages and the chip pins.
- Arbitrates, registers the winning request onto the bus, waits for the acknowledge, and returns data plus a one-cycle ready pulse to the winner.
- A watchdog aborts transfers that are never acknowledged.

Parameters:
- TIMEOUT, 16: max cycles in a BUSY state waiting for ack before abort; 0 disables the watchdog.
- FETCH_SIZE, 2'b10: SIZE code driven for instruction fetches (word).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- i_req  in  1  fetch request, level
- i_addr  in  32  fetch address
- i_ready  out  1  fetch complete, 1-cycle pulse
- i_rdata  out  32  fetched instruction, held until next fetch completion
- i_err  out  1  valid with i_ready; 1 = timeout abort
- d_req  in  1  data request, level
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  access SIZE code, passed through
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_ready  out  1  data complete, 1-cycle pulse
- d_rdata  out  32  load data, held until next data completion
- d_err  out  1  valid with d_ready; 1 = timeout abort
- bus_addr  out  32  external address
- bus_mreq  out  1  request, active high
- bus_write  out  1  write, active high
- bus_size  out  2  access size
- bus_wdata  out  32  write data
- bus_wdata_oe  out  1  enable for the external DDT tri-state driver
- bus_rdata  in  32  external read data
- bus_ack_n  in  1  acknowledge, active low
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, BUSY_I, BUSY_D. All outputs are registered.
- Reset (async, immediate):
  - state = IDLE, watchdog = 0.
  - All bus outputs = 0, including bus_mreq and bus_wdata_oe.
  - ready/err/rdata outputs = 0.
  - Reset mid-transfer abandons the transfer with no ready pulse.
- IDLE, sampled at each edge:
  - d_req=1 -> BUSY_D. Data wins over fetch when both are requesting.
  - else i_req=1 -> BUSY_I.
  - else stay in IDLE.
  - On entry to a BUSY state, latch the request fields. Drive bus_mreq=1 and the latched addr/write/size from the first BUSY cycle.
  - For stores, also drive bus_wdata = latched d_wdata and bus_wdata_oe=1.
  - Fetch: bus_write=0, bus_size=FETCH_SIZE.
- Bus fields stay constant for the whole BUSY state. Requester input changes during BUSY are ignored.
- Completion: bus_ack_n=0 sampled at an edge while in BUSY_x.
  - Capture bus_rdata into x_rdata (loads and fetches only; stores leave d_rdata unchanged).
  - Pulse x_ready=1 with x_err=0 for the next cycle.
- Handoff at the completion edge:
  - If the other requester's req=1, go directly to its BUSY state with no IDLE bubble.
  - Otherwise go to IDLE and drop bus_mreq/bus_wdata_oe to 0.
  - The completed requester is never re-granted at its own completion edge. Under sustained contention, grants therefore alternate D, I, D, I.
- Minimum latency: req sampled at edge 0 -> bus driven in cycle 1 -> ack at edge 1 earliest -> ready high in cycle 2.
- Requester rule:
  - Hold req and fields stable until ready is seen.
  - Deassert req in the ready cycle, unless a new transfer is wanted; req still high at the end of the ready cycle counts as a new request.
- Watchdog:
  - Counts cycles spent in BUSY without ack and clears on every state entry.
  - When TIMEOUT!=0 and the count reaches TIMEOUT with no ack, abort: x_ready=1 and x_err=1 for one cycle, x_rdata=0, then follow the normal handoff.
  - Ack on the same edge as the timeout counts as success.
- bus_ack_n=0 while IDLE is ignored.
- busy = 1 in either BUSY state.

Test Plan:
- Single fetch: i_req=1, i_addr=0x100, ack_n low for one edge after 2 wait cycles, bus_rdata=0x00000013 -> bus_addr=0x100, mreq=1, write=0, size=2'b10 for 3 cycles; i_ready pulse, i_rdata=0x13, i_err=0; then mreq=0.
- Simultaneous requests: d_req store to 0x2000 with wdata 0xDEADBEEF and i_req to 0x104, both raised at the same edge -> store first (write=1, oe=1, wdata=0xDEADBEEF); at the ack edge the fetch of 0x104 starts the next cycle with no idle cycle; d_ready then i_ready.
- Sustained contention, both reqs re-raised continuously, ack every cycle -> grant order D, I, D, I over 8 transfers; each requester stalls at most one transfer.
- Timeout, TIMEOUT=8, load with ack never asserted -> after 8 BUSY cycles: d_ready=1, d_err=1, d_rdata=0, mreq drops next cycle.
- Reset mid-transfer: rst pulsed during BUSY_D -> mreq and oe go 0 immediately; no d_ready; after release, a fresh fetch completes normally.
- Spurious ack: bus_ack_n=0 while IDLE for 3 cycles -> no ready pulse, state stays IDLE.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the IF/MEM requesters, the arbiter and the external memory bus.
// master = arbiter side, slave = requesters plus the bus/memory environment.
interface mem_bus_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic        i_err;

    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        d_err;

    logic [31:0] bus_addr;
    logic        bus_mreq;
    logic        bus_write;
    logic [1:0]  bus_size;
    logic [31:0] bus_wdata;
    logic        bus_wdata_oe;
    logic [31:0] bus_rdata;
    logic        bus_ack_n;

    logic        busy;

    modport master (
        input  i_req, i_addr,
        output i_ready, i_rdata, i_err,
        input  d_req, d_we, d_size, d_addr, d_wdata,
        output d_ready, d_rdata, d_err,
        output bus_addr, bus_mreq, bus_write, bus_size, bus_wdata, bus_wdata_oe,
        input  bus_rdata, bus_ack_n,
        output busy
    );

    modport slave (
        output i_req, i_addr,
        input  i_ready, i_rdata, i_err,
        output d_req, d_we, d_size, d_addr, d_wdata,
        input  d_ready, d_rdata, d_err,
        input  bus_addr, bus_mreq, bus_write, bus_size, bus_wdata, bus_wdata_oe,
        output bus_rdata, bus_ack_n,
        input  busy
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-port (fetch / load-store) arbiter for a single external memory bus with
// registered bus outputs, data-port priority, alternating handoff and an ack watchdog.
module mem_bus_arbiter #(
    parameter int         TIMEOUT    = 16,
    parameter logic [1:0] FETCH_SIZE = 2'b10
) (
    input logic               clk,
    input logic               rst,
    mem_bus_arbiter_if.master mb
);
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t          state_q, state_d;
    logic [WD_W-1:0] wd_q;
    logic            ack, tmo, done, grant_i, grant_d;

    always_comb begin
        ack     = !mb.bus_ack_n;
        tmo     = 1'b0;
        grant_i = 1'b0;
        grant_d = 1'b0;
        state_d = state_q;
        // An ack on the timeout edge wins: tmo only fires without ack.
        if (TIMEOUT != 0 && state_q != IDLE && !ack && wd_q == WD_LAST)
            tmo = 1'b1;
        done = (state_q != IDLE) && (ack || tmo);

        case (state_q)
            IDLE: begin
                if (mb.d_req)      grant_d = 1'b1;
                else if (mb.i_req) grant_i = 1'b1;
            end
            BUSY_I: begin
                if (done) begin
                    if (mb.d_req) grant_d = 1'b1;
                    else          state_d = IDLE;
                end
            end
            BUSY_D: begin
                if (done) begin
                    if (mb.i_req) grant_i = 1'b1;
                    else          state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (grant_d) state_d = BUSY_D;
        if (grant_i) state_d = BUSY_I;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q            <= '0;
            mb.i_ready      <= 1'b0;
            mb.i_err        <= 1'b0;
            mb.i_rdata      <= '0;
            mb.d_ready      <= 1'b0;
            mb.d_err        <= 1'b0;
            mb.d_rdata      <= '0;
            mb.bus_addr     <= '0;
            mb.bus_mreq     <= 1'b0;
            mb.bus_write    <= 1'b0;
            mb.bus_size     <= '0;
            mb.bus_wdata    <= '0;
            mb.bus_wdata_oe <= 1'b0;
            mb.busy         <= 1'b0;
        end else begin
            mb.i_ready <= 1'b0;
            mb.i_err   <= 1'b0;
            mb.d_ready <= 1'b0;
            mb.d_err   <= 1'b0;
            mb.busy    <= (state_d != IDLE);

            // Every grant changes state, so a state change is exactly a BUSY entry or exit.
            if (state_d != state_q)
                wd_q <= '0;
            else if (state_q != IDLE && wd_q != {WD_W{1'b1}})
                wd_q <= wd_q + WD_W'(1);

            if (done && state_q == BUSY_I) begin
                mb.i_ready <= 1'b1;
                mb.i_err   <= tmo;
                mb.i_rdata <= tmo ? '0 : mb.bus_rdata;
            end
            if (done && state_q == BUSY_D) begin
                mb.d_ready <= 1'b1;
                mb.d_err   <= tmo;
                if (tmo)                mb.d_rdata <= '0;
                else if (!mb.bus_write) mb.d_rdata <= mb.bus_rdata;
            end

            if (grant_d) begin
                mb.bus_addr     <= mb.d_addr;
                mb.bus_mreq     <= 1'b1;
                mb.bus_write    <= mb.d_we;
                mb.bus_size     <= mb.d_size;
                mb.bus_wdata    <= mb.d_we ? mb.d_wdata : '0;
                mb.bus_wdata_oe <= mb.d_we;
            end else if (grant_i) begin
                mb.bus_addr     <= mb.i_addr;
                mb.bus_mreq     <= 1'b1;
                mb.bus_write    <= 1'b0;
                mb.bus_size     <= FETCH_SIZE;
                mb.bus_wdata    <= '0;
                mb.bus_wdata_oe <= 1'b0;
            end else if (done) begin
                mb.bus_mreq     <= 1'b0;
                mb.bus_wdata_oe <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: table-driven single transfers plus hand-written
// contention, timeout, reset and spurious-ack sequences, checked through grant/completion queues.
module tb_mem_bus_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_bus_arbiter_if mb();
    mem_bus_arbiter #(.TIMEOUT(8), .FETCH_SIZE(2'b10)) dut (.clk(clk), .rst(rst), .mb(mb));

    typedef struct {logic [31:0] addr; logic write; logic [1:0] size; logic [31:0] wdata;} grant_t;
    typedef struct {logic is_d; logic [31:0] rdata; logic err;} cpl_t;
    typedef struct {bit is_d; bit we; logic [1:0] size; logic [31:0] addr; logic [31:0] wdata; int wait_n;} vec_t;

    int total = 0;
    int bad   = 0;
    grant_t gq[$];
    cpl_t   cq[$];
    bit ack_en = 1'b1;
    bit spur   = 1'b0;
    int ack_wait = 0;
    logic [31:0] exp_i = '0, exp_d = '0;
    int lat_d, lat_i;

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return a ^ 32'h0000_0113;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic flag(input string nm, input logic [31:0] act);
        total++;
        bad++;
        $display("FAIL %s: got %h want nothing", nm, act);
    endtask

    task automatic push_g(input logic [31:0] a, input logic w, input logic [1:0] s, input logic [31:0] wd);
        grant_t g;
        g.addr = a; g.write = w; g.size = s; g.wdata = wd;
        gq.push_back(g);
    endtask

    task automatic push_c(input logic is_d, input logic [31:0] rd, input logic err);
        cpl_t c;
        c.is_d = is_d; c.rdata = rd; c.err = err;
        cq.push_back(c);
    endtask

    // Monitor first, then the memory responder, both on the falling edge.
    initial begin : mon
        grant_t cur;
        cpl_t   c;
        bit     prev_mreq;
        int     cnt;
        prev_mreq = 1'b0;
        cnt = 0;
        cur.addr = '0; cur.write = 1'b0; cur.size = '0; cur.wdata = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mb.bus_mreq && (!prev_mreq || !mb.bus_ack_n)) begin
                    if (gq.size() == 0) flag("unexpected_grant", mb.bus_addr);
                    else cur = gq.pop_front();
                end
                if (mb.bus_mreq) begin
                    chk("bus_addr", mb.bus_addr, cur.addr);
                    chk("bus_write", 32'(mb.bus_write), 32'(cur.write));
                    chk("bus_size", 32'(mb.bus_size), 32'(cur.size));
                    chk("bus_oe", 32'(mb.bus_wdata_oe), 32'(cur.write));
                    if (cur.write) chk("bus_wdata", mb.bus_wdata, cur.wdata);
                end
                if (mb.i_ready && mb.d_ready) flag("both_ready", 32'h3);
                else if (mb.i_ready || mb.d_ready) begin
                    if (cq.size() == 0) flag("unexpected_ready", {30'd0, mb.d_ready, mb.i_ready});
                    else begin
                        c = cq.pop_front();
                        chk("ready_port", 32'(mb.d_ready), 32'(c.is_d));
                        if (c.is_d) begin
                            chk("d_rdata", mb.d_rdata, c.rdata);
                            chk("d_err", 32'(mb.d_err), 32'(c.err));
                        end else begin
                            chk("i_rdata", mb.i_rdata, c.rdata);
                            chk("i_err", 32'(mb.i_err), 32'(c.err));
                        end
                    end
                end
            end
            prev_mreq = mb.bus_mreq;
            if (spur) mb.bus_ack_n = 1'b0;
            else if (mb.bus_mreq && ack_en) begin
                if (cnt >= ack_wait) begin mb.bus_ack_n = 1'b0; cnt = 0; end
                else begin mb.bus_ack_n = 1'b1; cnt++; end
            end else begin
                mb.bus_ack_n = 1'b1;
                cnt = 0;
            end
            mb.bus_rdata = rd_fn(mb.bus_addr);
        end
    end

    // One transfer: raise req, wait (bounded) for the ready pulse, drop req in the ready cycle.
    task automatic run_req(input bit is_d, input bit we, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd, output int lat);
        lat = -1;
        if (is_d) begin
            mb.d_we = we; mb.d_size = sz; mb.d_addr = a; mb.d_wdata = wd; mb.d_req = 1'b1;
        end else begin
            mb.i_addr = a; mb.i_req = 1'b1;
        end
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (is_d ? mb.d_ready : mb.i_ready) begin lat = n; break; end
        end
        if (is_d) mb.d_req = 1'b0; else mb.i_req = 1'b0;
        if (lat < 0) flag("ready_wait_expired", a);
    endtask

    // Back-to-back loads/fetches with req held high across ready cycles.
    task automatic stream(input bit is_d, input logic [31:0] base, input int count, output int last);
        int n;
        n = 0;
        last = -1;
        if (is_d) begin mb.d_we = 1'b0; mb.d_size = 2'b10; mb.d_addr = base; mb.d_req = 1'b1; end
        else begin mb.i_addr = base; mb.i_req = 1'b1; end
        for (int k = 0; k < count; k++) begin
            while (!(is_d ? mb.d_ready : mb.i_ready) || n == 0 || last == n) begin
                @(negedge clk);
                n++;
                if (n > 200) break;
            end
            if (n > 200) begin flag("stream_expired", base); break; end
            last = n;
            if (k < count - 1) begin
                if (is_d) mb.d_addr = base + 32'(8 * (k + 1));
                else      mb.i_addr = base + 32'(4 * (k + 1));
            end else begin
                if (is_d) mb.d_req = 1'b0; else mb.i_req = 1'b0;
            end
        end
    endtask

    initial begin : main
        vec_t vt[6];
        int lat;
        mb.i_req = 1'b0; mb.i_addr = '0;
        mb.d_req = 1'b0; mb.d_we = 1'b0; mb.d_size = '0; mb.d_addr = '0; mb.d_wdata = '0;
        mb.bus_rdata = '0; mb.bus_ack_n = 1'b1;

        vt[0] = '{1'b0, 1'b0, 2'b00, 32'h0000_0100, 32'h0,         2};
        vt[1] = '{1'b1, 1'b0, 2'b10, 32'h0000_2004, 32'h0,         0};
        vt[2] = '{1'b1, 1'b1, 2'b01, 32'h0000_2008, 32'h1234_5678, 1};
        vt[3] = '{1'b0, 1'b0, 2'b00, 32'h0000_0104, 32'h0,         0};
        vt[4] = '{1'b1, 1'b0, 2'b00, 32'h0000_200C, 32'h0,         7};
        vt[5] = '{1'b1, 1'b1, 2'b11, 32'h0000_3000, 32'hA5A5_5A5A, 3};

        #12;
        chk("rst_mreq", 32'(mb.bus_mreq), 0);
        chk("rst_oe", 32'(mb.bus_wdata_oe), 0);
        chk("rst_addr", mb.bus_addr, 0);
        chk("rst_busy", 32'(mb.busy), 0);
        chk("rst_ready", {30'd0, mb.d_ready, mb.i_ready}, 0);
        chk("rst_rdata", mb.i_rdata | mb.d_rdata, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            ack_wait = vt[v].wait_n;
            if (vt[v].is_d) begin
                push_g(vt[v].addr, vt[v].we, vt[v].size, vt[v].wdata);
                if (!vt[v].we) exp_d = rd_fn(vt[v].addr);
                push_c(1'b1, exp_d, 1'b0);
            end else begin
                push_g(vt[v].addr, 1'b0, 2'b10, 32'h0);
                exp_i = rd_fn(vt[v].addr);
                push_c(1'b0, exp_i, 1'b0);
            end
            run_req(vt[v].is_d, vt[v].we, vt[v].size, vt[v].addr, vt[v].wdata, lat);
            chk("vec_latency", 32'(lat), 32'(vt[v].wait_n + 2));
            chk("vec_mreq_after", 32'(mb.bus_mreq), 0);
            @(negedge clk);
            chk("vec_busy_after", 32'(mb.busy), 0);
        end

        // Store and fetch raised together: store first, fetch follows with no idle cycle.
        ack_wait = 1;
        push_g(32'h0000_2000, 1'b1, 2'b10, 32'hDEAD_BEEF);
        push_g(32'h0000_0104, 1'b0, 2'b10, 32'h0);
        push_c(1'b1, exp_d, 1'b0);
        exp_i = rd_fn(32'h0000_0104);
        push_c(1'b0, exp_i, 1'b0);
        fork
            run_req(1'b1, 1'b1, 2'b10, 32'h0000_2000, 32'hDEAD_BEEF, lat_d);
            run_req(1'b0, 1'b0, 2'b00, 32'h0000_0104, 32'h0, lat_i);
        join
        chk("simul_d_lat", 32'(lat_d), 3);
        chk("simul_i_lat", 32'(lat_i), 5);
        repeat (2) @(negedge clk);

        // Sustained contention with ack every cycle: D, I, D, I ...
        ack_wait = 0;
        for (int k = 0; k < 4; k++) begin
            push_g(32'h0000_4000 + 32'(8 * k), 1'b0, 2'b10, 32'h0);
            push_g(32'h0000_0500 + 32'(4 * k), 1'b0, 2'b10, 32'h0);
        end
        for (int k = 0; k < 4; k++) begin
            push_c(1'b1, rd_fn(32'h0000_4000 + 32'(8 * k)), 1'b0);
            push_c(1'b0, rd_fn(32'h0000_0500 + 32'(4 * k)), 1'b0);
        end
        fork
            stream(1'b1, 32'h0000_4000, 4, lat_d);
            stream(1'b0, 32'h0000_0500, 4, lat_i);
        join
        exp_d = rd_fn(32'h0000_4018);
        exp_i = rd_fn(32'h0000_050C);
        chk("cont_d_last", 32'(lat_d), 8);
        chk("cont_i_last", 32'(lat_i), 9);
        repeat (2) @(negedge clk);

        // Load never acknowledged: watchdog abort after 8 BUSY cycles.
        ack_en = 1'b0;
        push_g(32'h0000_3000, 1'b0, 2'b10, 32'h0);
        exp_d = 32'h0;
        push_c(1'b1, exp_d, 1'b1);
        run_req(1'b1, 1'b0, 2'b10, 32'h0000_3000, 32'h0, lat);
        chk("tmo_latency", 32'(lat), 9);
        chk("tmo_mreq_drop", 32'(mb.bus_mreq), 0);
        @(negedge clk);
        chk("tmo_busy_after", 32'(mb.busy), 0);

        // Reset in the middle of an unacknowledged store.
        push_g(32'h0000_6000, 1'b1, 2'b10, 32'hCAFE_F00D);
        mb.d_we = 1'b1; mb.d_size = 2'b10; mb.d_addr = 32'h0000_6000;
        mb.d_wdata = 32'hCAFE_F00D; mb.d_req = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_rst_oe", 32'(mb.bus_wdata_oe), 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_mreq", 32'(mb.bus_mreq), 0);
        chk("rst_mid_oe", 32'(mb.bus_wdata_oe), 0);
        chk("rst_mid_busy", 32'(mb.busy), 0);
        mb.d_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ack_en = 1'b1;
        exp_d = 32'h0;
        chk("rst_mid_no_ready", 32'(mb.d_ready), 0);
        ack_wait = 1;
        push_g(32'h0000_0108, 1'b0, 2'b10, 32'h0);
        exp_i = rd_fn(32'h0000_0108);
        push_c(1'b0, exp_i, 1'b0);
        run_req(1'b0, 1'b0, 2'b00, 32'h0000_0108, 32'h0, lat);
        chk("post_rst_lat", 32'(lat), 3);
        @(negedge clk);

        // Ack while idle must be ignored.
        spur = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("spur_busy", 32'(mb.busy), 0);
            chk("spur_mreq", 32'(mb.bus_mreq), 0);
        end
        spur = 1'b0;
        repeat (2) @(negedge clk);
        chk("spur_busy_end", 32'(mb.busy), 0);
        chk("spur_d_rdata_held", mb.d_rdata, exp_d);
        chk("grant_q_drained", 32'(gq.size()), 0);
        chk("cpl_q_drained", 32'(cq.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
